// File: rtl/cpu_sequencer.sv
// Control-state generator for the accumulator CPU: sequences FETCH/EXEC1/EXEC2,
// latches the opcode, handles run / single-step / halt and keeps debug counters.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for run or a step pulse; no cycles counted
// S_FETCH | opcode on ram_q is captured into IR
// S_EXEC1 | first execute cycle; may halt, extend, overlap-fetch or finish
// S_EXEC2 | second execute cycle for instructions the decoder flags EXTRA
// S_HALT  | STP executed; absorbing until reset
module cpu_sequencer #(
   parameter int DATA_W = 16,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              run,
   input  logic              step,
   input  logic              EXTRA,
   input  logic              TF,
   input  logic [DATA_W-1:0] ram_q,
   output logic              FETCH,
   output logic              EXEC1,
   output logic              EXEC2,
   output logic [3:0]        IR,
   output logic              IR_LOAD,
   output logic              halted,
   output logic              busy,
   output logic [CNT_W-1:0]  cycle_count,
   output logic [CNT_W-1:0]  instr_count
);

   localparam logic [3:0] OP_STP = 4'b0111;
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_FETCH = 3'd1,
      S_EXEC1 = 3'd2,
      S_EXEC2 = 3'd3,
      S_HALT  = 3'd4
   } state_t;

   state_t state;
   state_t next_state;
   logic   step_flag;
   logic   step_flag_next;
   logic   stop_after_instr;
   logic [3:0] opcode;

   // Only the opcode field of the memory word matters here.
   logic ram_q_unused;
   assign ram_q_unused = ^ram_q[DATA_W-5:0];
   assign opcode       = ram_q[DATA_W-1 -: 4];

   // A completed instruction returns to IDLE when single-stepping or when run has dropped.
   assign stop_after_instr = step_flag | ~run;

   // State register and step-mode flag.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= S_IDLE;
         step_flag <= 1'b0;
      end else begin
         state     <= next_state;
         step_flag <= step_flag_next;
      end
   end

   // Next-state and IR load decision; overlapped fetch stays in EXEC1.
   always_comb begin
      next_state     = state;
      step_flag_next = step_flag;
      IR_LOAD        = 1'b0;
      case (state)
         S_IDLE: begin
            if (run) begin
               next_state     = S_FETCH;
               step_flag_next = 1'b0;
            end else if (step) begin
               next_state     = S_FETCH;
               step_flag_next = 1'b1;
            end
         end
         S_FETCH: begin
            IR_LOAD    = 1'b1;
            next_state = S_EXEC1;
         end
         S_EXEC1: begin
            if (IR == OP_STP) begin
               next_state = S_HALT;
            end else if (EXTRA) begin
               next_state = S_EXEC2;
            end else if (stop_after_instr) begin
               next_state = S_IDLE;
            end else if (TF) begin
               IR_LOAD    = 1'b1;
               next_state = S_EXEC1;
            end else begin
               next_state = S_FETCH;
            end
         end
         S_EXEC2: begin
            next_state = stop_after_instr ? S_IDLE : S_FETCH;
         end
         S_HALT: begin
            next_state = S_HALT;
         end
         default: begin
            next_state = S_IDLE;
         end
      endcase
   end

   // Registered state decodes, loaded from next_state so they align with state.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         FETCH  <= 1'b0;
         EXEC1  <= 1'b0;
         EXEC2  <= 1'b0;
         halted <= 1'b0;
         busy   <= 1'b0;
      end else begin
         FETCH  <= (next_state == S_FETCH);
         EXEC1  <= (next_state == S_EXEC1);
         EXEC2  <= (next_state == S_EXEC2);
         halted <= (next_state == S_HALT);
         busy   <= (next_state != S_IDLE) && (next_state != S_HALT);
      end
   end

   // Instruction register captures the opcode field on every IR load.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         IR <= 4'b0000;
      end else if (IR_LOAD) begin
         IR <= opcode;
      end
   end

   // Saturating debug counters: active cycles and loaded opcodes.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cycle_count <= '0;
         instr_count <= '0;
      end else begin
         if (busy && (cycle_count != CNT_MAX)) begin
            cycle_count <= cycle_count + 1'b1;
         end
         if (IR_LOAD && (instr_count != CNT_MAX)) begin
            instr_count <= instr_count + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer; a second instance with 4-bit counters
// shares the stimulus to exercise counter saturation.
module tb_cpu_sequencer;

   logic        clk;
   logic        reset;
   logic        run;
   logic        step;
   logic        EXTRA;
   logic        TF;
   logic [15:0] ram_q;

   logic        FETCH, EXEC1, EXEC2, IR_LOAD, halted, busy;
   logic [3:0]  IR;
   logic [15:0] cycle_count, instr_count;

   logic        s_fetch, s_exec1, s_exec2, s_ir_load, s_halted, s_busy;
   logic [3:0]  s_ir;
   logic [3:0]  s_cycle_count, s_instr_count;

   int n_cmp;
   int n_err;

   cpu_sequencer #(.DATA_W(16), .CNT_W(16)) u_dut (
      .clk(clk), .reset(reset), .run(run), .step(step), .EXTRA(EXTRA), .TF(TF),
      .ram_q(ram_q), .FETCH(FETCH), .EXEC1(EXEC1), .EXEC2(EXEC2), .IR(IR),
      .IR_LOAD(IR_LOAD), .halted(halted), .busy(busy),
      .cycle_count(cycle_count), .instr_count(instr_count)
   );

   cpu_sequencer #(.DATA_W(16), .CNT_W(4)) u_small (
      .clk(clk), .reset(reset), .run(run), .step(step), .EXTRA(EXTRA), .TF(TF),
      .ram_q(ram_q), .FETCH(s_fetch), .EXEC1(s_exec1), .EXEC2(s_exec2), .IR(s_ir),
      .IR_LOAD(s_ir_load), .halted(s_halted), .busy(s_busy),
      .cycle_count(s_cycle_count), .instr_count(s_instr_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // State one-hot as {FETCH,EXEC1,EXEC2}
   function automatic logic [31:0] st();
      return {29'd0, FETCH, EXEC1, EXEC2};
   endfunction

   task automatic pulse_reset();
      reset = 1'b1;
      #1;
      reset = 1'b0;
      #1;
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      reset = 1'b1;
      run   = 1'b0;
      step  = 1'b0;
      EXTRA = 1'b0;
      TF    = 1'b0;
      ram_q = 16'h0000;
      tick();
      tick();
      chk("reset_state", st(), 32'd0);
      chk("reset_busy", 32'(busy), 32'd0);

      // LDA with EXTRA under free run, then reset in the middle of EXEC2.
      reset = 1'b0;
      run   = 1'b1;
      EXTRA = 1'b1;
      ram_q = 16'h0abc;
      tick();
      chk("lda_fetch", st(), 32'b100);
      chk("lda_irload", 32'(IR_LOAD), 32'd1);
      tick();
      chk("lda_exec1", st(), 32'b010);
      chk("lda_ir", 32'(IR), 32'h0);
      ram_q = 16'h5123;
      tick();
      chk("lda_exec2", st(), 32'b001);
      tick();
      chk("lda_fetch2", st(), 32'b100);
      chk("lda_instr", 32'(instr_count), 32'd1);
      chk("lda_cycle", 32'(cycle_count), 32'd3);
      tick();
      tick();
      chk("op5_exec2", st(), 32'b001);
      chk("op5_ir", 32'(IR), 32'h5);
      reset = 1'b1;
      #1;
      chk("rst_mid_state", st(), 32'd0);
      chk("rst_mid_ir", 32'(IR), 32'h0);
      chk("rst_mid_cycle", 32'(cycle_count), 32'd0);
      chk("rst_mid_instr", 32'(instr_count), 32'd0);
      chk("rst_mid_busy", 32'(busy), 32'd0);
      tick();

      // STA with overlapped fetch of opcode 0100.
      reset = 1'b0;
      run   = 1'b1;
      EXTRA = 1'b0;
      TF    = 1'b1;
      ram_q = 16'h1000;
      tick();
      chk("sta_fetch", st(), 32'b100);
      tick();
      chk("sta_exec1", st(), 32'b010);
      chk("sta_ir", 32'(IR), 32'h1);
      ram_q = 16'h4000;
      #1;
      chk("sta_tf_irload", 32'(IR_LOAD), 32'd1);
      tick();
      chk("tf_exec1_again", st(), 32'b010);
      chk("tf_ir", 32'(IR), 32'h4);
      chk("tf_irload", 32'(IR_LOAD), 32'd1);
      chk("tf_instr", 32'(instr_count), 32'd2);

      // Single step ADD with EXTRA.
      run   = 1'b0;
      TF    = 1'b0;
      EXTRA = 1'b1;
      ram_q = 16'h2000;
      step  = 1'b1;
      pulse_reset();
      tick();
      chk("step_fetch", st(), 32'b100);
      step = 1'b0;
      tick();
      chk("step_exec1", st(), 32'b010);
      chk("step_ir", 32'(IR), 32'h2);
      tick();
      chk("step_exec2", st(), 32'b001);
      tick();
      chk("step_idle", st(), 32'd0);
      repeat (3) tick();
      chk("step_busy_low", 32'(busy), 32'd0);
      chk("step_instr", 32'(instr_count), 32'd1);
      chk("step_cycle", 32'(cycle_count), 32'd3);

      // run and step together: run wins, so the sequencer keeps going.
      run  = 1'b1;
      step = 1'b1;
      tick();
      chk("both_fetch", st(), 32'b100);
      step = 1'b0;
      tick();
      tick();
      tick();
      chk("freerun_fetch", st(), 32'b100);
      chk("freerun_busy", 32'(busy), 32'd1);

      // run drops in EXEC1: the instruction still finishes through EXEC2.
      tick();
      chk("drop_exec1", st(), 32'b010);
      run = 1'b0;
      tick();
      chk("drop_exec2", st(), 32'b001);
      tick();
      chk("drop_idle", st(), 32'd0);
      chk("drop_busy", 32'(busy), 32'd0);

      // STP halts and ignores run/step.
      run   = 1'b1;
      EXTRA = 1'b0;
      ram_q = 16'h7000;
      pulse_reset();
      tick();
      chk("stp_fetch", st(), 32'b100);
      tick();
      chk("stp_exec1", st(), 32'b010);
      tick();
      chk("stp_halt_state", st(), 32'd0);
      chk("stp_halted", 32'(halted), 32'd1);
      chk("stp_busy", 32'(busy), 32'd0);
      run  = 1'b0;
      step = 1'b1;
      tick();
      run  = 1'b1;
      step = 1'b0;
      tick();
      step = 1'b1;
      tick();
      step = 1'b0;
      tick();
      chk("halt_sticky", 32'(halted), 32'd1);
      chk("halt_state", st(), 32'd0);
      chk("halt_cycle", 32'(cycle_count), 32'd2);
      chk("halt_instr", 32'(instr_count), 32'd1);
      reset = 1'b1;
      #1;
      chk("halt_rst_halted", 32'(halted), 32'd0);
      chk("halt_rst_busy", 32'(busy), 32'd0);
      tick();

      // Back-to-back overlapped fetches for 20 cycles.
      reset = 1'b0;
      run   = 1'b1;
      TF    = 1'b1;
      ram_q = 16'h1000;
      repeat (20) tick();
      chk("sat_cycle_small", 32'(s_cycle_count), 32'd15);
      chk("sat_instr_small", 32'(s_instr_count), 32'd15);
      chk("sat_cycle_wide", 32'(cycle_count), 32'd19);
      chk("sat_instr_wide", 32'(instr_count), 32'd19);
      tick();
      chk("sat_hold_small", 32'(s_instr_count), 32'd15);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
